// File: rtl/tdm_deserializer.sv
// tdm_deserializer: counts TDM slots and steers each serial word into its lane, emitting one parallel frame per WAY words
package tdm_pkg;
    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

module tdm_deserializer
    import tdm_pkg::*;
#(
    parameter int WAY = 8,
    parameter int WIRE = 1,
    parameter bit REQUIRE_SOF = 1'b1,
    localparam int SIZE_CTRL = log2(WAY),
    localparam int SIZE_OUT = WAY * WIRE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIRE-1:0]      in_data,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIZE_OUT-1:0]  out_data,
    output logic [SIZE_CTRL-1:0] slot,
    output logic                 err_resync
);
    typedef enum logic {HUNT, FILL} state_t;
    state_t                state_q, state_d;
    logic [SIZE_CTRL-1:0]  slot_q, slot_d;
    logic [SIZE_OUT-1:0]   asm_q, asm_d;
    logic [SIZE_OUT-1:0]   out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  err_q, err_d;
    logic                  last, acc;
    assign last = slot_q == SIZE_CTRL'(WAY - 1);
    assign in_ready = !(state_q == FILL && last && out_valid_q && !out_ready);
    assign acc = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign slot = slot_q;
    assign err_resync = err_q;
    always_comb begin
        state_d = state_q;
        slot_d = slot_q;
        asm_d = asm_q;
        out_data_d = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        err_d = 1'b0;
        if (acc) begin
            if (state_q == HUNT) begin
                if (in_sof) begin
                    asm_d[WIRE-1:0] = in_data;
                    slot_d = SIZE_CTRL'(1);
                    state_d = FILL;
                end
            end else if (in_sof && slot_q != '0) begin
                asm_d[WIRE-1:0] = in_data;
                slot_d = SIZE_CTRL'(1);
                err_d = 1'b1;
            end else begin
                asm_d[int'(slot_q)*WIRE +: WIRE] = in_data;
                slot_d = slot_q + 1'b1;
                if (last) begin
                    out_data_d = {in_data, asm_q[SIZE_OUT-WIRE-1:0]};
                    out_valid_d = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQUIRE_SOF ? HUNT : FILL;
            slot_q <= '0;
            asm_q <= '0;
            out_data_q <= '0;
            out_valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q <= slot_d;
            asm_q <= asm_d;
            out_data_q <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q <= err_d;
        end
    end
endmodule

// File: doc/tdm_deserializer.md
Name: tdm_deserializer

Overview:
- Receive end of a time-division link: the transmit side serialises WAY lanes of WIRE bits each onto one WIRE-bit word stream, using a mux tree selected by a slot counter.
- This block counts slots and steers each received word into its lane position, like a registered demux.
- When WAY words have arrived, it presents one parallel frame with valid/ready backpressure.
- Sits between the serial link and the wide lane-parallel datapath.

Parameters:
- WAY, 8, lanes per frame; power of two, >= 2.
- WIRE, 1, bits per lane word.
- REQUIRE_SOF, 1, 1 = discard words after reset until the first in_sof; 0 = start filling at slot 0 straight out of reset.
- Derived localparam SIZE_CTRL = ceil(log2(WAY)), computed with the codebase log2 function.
- Derived localparam SIZE_OUT = WAY*WIRE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_sof are valid this cycle.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIRE  serial lane word.
- in_sof  in  1  word is slot 0 of a new frame.
- out_valid  out  1  out_data holds a complete frame.
- out_ready  in  1  downstream takes the frame.
- out_data  out  SIZE_OUT  frame; lane k at bits [(k+1)*WIRE-1 : k*WIRE] (lane 0 at LSB, same ordering as mux/demux).
- slot  out  SIZE_CTRL  index the next accepted word will occupy.
- err_resync  out  1  one-cycle pulse: partial frame dropped by an early in_sof.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, slot=0, err_resync=0, assembly register=0.
  - State after reset: HUNT if REQUIRE_SOF=1, else FILL.
- Accept event: acc = in_valid & in_ready.
- HUNT state:
  - in_ready=1.
  - Words with in_sof=0 are accepted and dropped; slot stays 0.
  - Accepted word with in_sof=1: written to lane 0, slot<=1, next state FILL.
- FILL state, accepted word:
  - Written to assembly lane slot.
  - slot <= slot+1, wrapping from WAY-1 to 0.
- Last slot (slot==WAY-1) accepted:
  - out_data <= {in_data, assembly lanes WAY-2..0}.
  - out_valid <= 1 next cycle.
  - slot <= 0; state stays FILL.
- Latency: frame visible on out_data one cycle after the last word is accepted.
- in_ready rules:
  - in_ready = !(state==FILL && slot==WAY-1 && out_valid && !out_ready).
  - Stalls only the last word of a frame while the previous frame is unconsumed.
  - Consume and refill in the same cycle is allowed, so full throughput is sustained.
- Output handshake:
  - out_valid & out_ready and no new frame completing -> out_valid<=0; out_data holds its value.
  - out_data is stable while out_valid=1 and out_ready=0.
- in_sof accepted in FILL with slot!=0 (resync):
  - Partial frame discarded, never output.
  - Word goes to lane 0, slot<=1, err_resync pulses one cycle.
  - Stale assembly lanes are not cleared; they are overwritten as the frame refills.
- in_sof accepted with slot==0: normal case, no error.
- WAY==2, in_sof on slot 1: resync takes priority over frame completion, so no frame is emitted.
- in_sof and in_data are ignored when in_valid=0.
- in_sof on a stalled last word: the word is not accepted, so no action until in_ready=1.
- Reset mid-frame: partial frame and pending output are lost; out_valid drops immediately (asynchronously).

Test Plan (WAY=4, WIRE=8 unless stated):
1. REQUIRE_SOF=1: send 0x11,0x22 without sof, then sof+0xA0,0xA1,0xA2,0xA3 with out_ready=1 -> one frame out_data=0xA3A2A1A0 one cycle after 0xA3; err_resync never pulses.
2. Back-to-back frames 0x03020100 and 0x07060504, in_valid and out_ready held 1 -> in_ready stays 1, out_valid high on two cycles 4 apart, correct data each.
3. Frame 1 complete, out_ready=0, frame 2 first three words sent -> in_ready drops at slot 3; out_data holds frame 1. Raise out_ready -> frame 2 last word accepted the same cycle, frame 2 appears next cycle.
4. sof+0x10,0x11, then sof+0x20,0x21,0x22,0x23 -> err_resync pulses on the cycle after the second sof is accepted; the only frame output is 0x23222120.
5. rst_n pulsed low mid-frame (slot=2, out_valid=1) -> outputs go to 0 immediately. With REQUIRE_SOF=1, the next non-sof words are dropped until sof.
6. WAY=2, WIRE=1, REQUIRE_SOF=0: stream 1,0,1,1 -> frames 2'b01 then 2'b11; slot toggles 0/1.
